// File: rtl/mbox.sv
// Memory-mapped mailbox FIFO: bus writes push 32-bit words, bus reads pop them
// one cycle later through a registered read port; optional fill-level interrupt.
module mbox #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          DEPTH     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mbox_r_addr_i,
    input  logic [31:0] mbox_w_addr_i,
    input  logic [31:0] mbox_data_i,
    input  logic        mbox_r_enable_i,
    input  logic        mbox_w_enable_i,
    output logic [31:0] mbox_data_o,
    output logic        mbox_irq_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d, udf_q, udf_d;
    logic          irq_en_q, irq_en_d;
    logic [4:0]    thr_q, thr_d;
    logic [31:0]   data_q, data_d;
    logic          irq_q, irq_d;

    logic [31:0] r_off, w_off;
    logic [29:0] r_word, w_word;
    logic        r_hit, w_hit;
    logic [1:0]  r_idx, w_idx;

    // Window check is done on the offset so a non-16-aligned base still works.
    assign r_off  = mbox_r_addr_i - BASE_ADDR;
    assign w_off  = mbox_w_addr_i - BASE_ADDR;
    assign r_word = 30'(r_off >> 2);
    assign w_word = 30'(w_off >> 2);
    assign r_hit  = r_word < 30'd4;
    assign w_hit  = w_word < 30'd4;
    assign r_idx  = r_word[1:0];
    assign w_idx  = w_word[1:0];

    logic        empty, full;
    logic        rd_acc, pop_req, pop_ok, push_req, push_ok;
    logic        ctrl_wr, flush, clr;
    logic        ovf_set, udf_set;
    logic [31:0] status_w, ctrl_w;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CW'(DEPTH));
        rd_acc   = mbox_r_enable_i && r_hit;
        pop_req  = rd_acc && (r_idx == 2'd0);
        pop_ok   = pop_req && !empty;
        udf_set  = pop_req && empty;
        ctrl_wr  = mbox_w_enable_i && w_hit && (w_idx == 2'd2);
        flush    = ctrl_wr && mbox_data_i[16];
        clr      = ctrl_wr && mbox_data_i[17];
        push_req = mbox_w_enable_i && w_hit && (w_idx == 2'd0) && !flush;
        push_ok  = push_req && (!full || pop_ok);
        ovf_set  = push_req && !push_ok;

        status_w       = '0;
        status_w[0]    = empty;
        status_w[1]    = full;
        status_w[2]    = ovf_q;
        status_w[3]    = udf_q;
        status_w[12:8] = 5'(count_q);
        ctrl_w         = '0;
        ctrl_w[0]      = irq_en_q;
        ctrl_w[12:8]   = thr_q;

        data_d = data_q;
        if (rd_acc) begin
            case (r_idx)
                2'd0:    data_d = pop_ok ? mem_q[rd_ptr_q] : 32'd0;
                2'd1:    data_d = status_w;
                2'd2:    data_d = ctrl_w;
                default: data_d = 32'd0;
            endcase
        end

        wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        // A flag raised this cycle survives a same-cycle clear-sticky.
        ovf_d = (ovf_q && !clr) || ovf_set;
        udf_d = (udf_q && !clr) || udf_set;

        irq_en_d = ctrl_wr ? mbox_data_i[0]    : irq_en_q;
        thr_d    = ctrl_wr ? mbox_data_i[12:8] : thr_q;
        irq_d    = irq_en_d && (thr_d != 5'd0) && (5'(count_d) >= thr_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            irq_en_q <= 1'b0;
            thr_q    <= '0;
            data_q   <= '0;
            irq_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            irq_en_q <= irq_en_d;
            thr_q    <= thr_d;
            data_q   <= data_d;
            irq_q    <= irq_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem_q[wr_ptr_q] <= mbox_data_i;
        end
    end

    assign mbox_data_o = data_q;
    assign mbox_irq_o  = irq_q;
endmodule

// File: tb/tb_mbox.sv
// Scoreboard bench for mbox: a queue-based mailbox model predicts read data and
// the interrupt level; a negedge monitor compares them against the DUT.
module tb_mbox;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] r_addr = '0, w_addr = '0, wdata = '0;
    logic        r_en = 1'b0, w_en = 1'b0;
    logic [31:0] data_o;
    logic        irq_o;

    always #5 clk = ~clk;

    mbox #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .mbox_r_addr_i  (r_addr),
        .mbox_w_addr_i  (w_addr),
        .mbox_data_i    (wdata),
        .mbox_r_enable_i(r_en),
        .mbox_w_enable_i(w_en),
        .mbox_data_o    (data_o),
        .mbox_irq_o     (irq_o)
    );

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [31:0] m_fifo[$];
    bit          m_ovf, m_udf, m_ien;
    logic [4:0]  m_thr;

    // scoreboard
    logic [31:0] exp_q[$];
    string       name_q[$];
    bit          rd_mark = 0, chk_pend = 0;
    bit          exp_irq = 0, exp_irq_next = 0;
    bit          started = 0;
    logic [31:0] exp_hold = '0;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        chk_pend <= rd_mark;
        exp_irq  <= exp_irq_next;
    end

    always @(negedge clk) begin
        string nm;
        if (started) begin
            nm = "hold";
            if (chk_pend) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL scoreboard: got empty queue expected an entry");
                end else begin
                    exp_hold = exp_q.pop_front();
                    nm = name_q.pop_front();
                end
            end
            check(nm, data_o, exp_hold);
            check("irq", {31'd0, irq_o}, {31'd0, exp_irq});
        end
    end

    // One bus cycle: drive inputs, step the model, wait for the edge.
    task automatic cyc(bit r, logic [31:0] ra, bit w, logic [31:0] wa, logic [31:0] wd,
                       bit rs = 0, string nm = "rd", bit use_k = 0, logic [31:0] k = '0);
        logic [31:0] roff, woff, v;
        bit rhit, whit, pop_ok, udf_set, ctrl_wr, flush, clr, push, ovf_set;
        int ridx, widx, pre_size;
        rst = rs; r_en = r; r_addr = ra; w_en = w; w_addr = wa; wdata = wd;
        rd_mark = 0;
        if (rs) begin
            m_fifo.delete();
            m_ovf = 0; m_udf = 0; m_ien = 0; m_thr = '0;
            exp_q.push_back(32'd0);
            name_q.push_back("rst");
            rd_mark = 1;
            exp_irq_next = 0;
        end else begin
            roff = ra - BASE; woff = wa - BASE;
            rhit = roff < 32'd16; whit = woff < 32'd16;
            ridx = int'(roff[3:2]); widx = int'(woff[3:2]);
            pre_size = m_fifo.size();
            v = '0;
            case (ridx)
                0: v = (pre_size > 0) ? m_fifo[0] : 32'd0;
                1: begin
                    v[0] = (pre_size == 0); v[1] = (pre_size == DEPTH);
                    v[2] = m_ovf; v[3] = m_udf; v[12:8] = 5'(pre_size);
                end
                2: begin v[0] = m_ien; v[12:8] = m_thr; end
                default: v = '0;
            endcase
            pop_ok  = r && rhit && ridx == 0 && pre_size > 0;
            udf_set = r && rhit && ridx == 0 && pre_size == 0;
            ctrl_wr = w && whit && widx == 2;
            flush   = ctrl_wr && wd[16];
            clr     = ctrl_wr && wd[17];
            push    = w && whit && widx == 0 && !flush;
            ovf_set = push && pre_size == DEPTH && !pop_ok;
            if (pop_ok) void'(m_fifo.pop_front());
            if (push && !ovf_set) m_fifo.push_back(wd);
            if (flush) m_fifo.delete();
            m_ovf = (m_ovf && !clr) || ovf_set;
            m_udf = (m_udf && !clr) || udf_set;
            if (ctrl_wr) begin m_ien = wd[0]; m_thr = wd[12:8]; end
            exp_irq_next = m_ien && m_thr != 0 && m_fifo.size() >= int'(m_thr);
            if (r && rhit) begin
                exp_q.push_back(use_k ? k : v);
                name_q.push_back(nm);
                rd_mark = 1;
            end
        end
        @(posedge clk);
        #1;
        rst = 0; r_en = 0; w_en = 0; rd_mark = 0;
    endtask

    task automatic push(logic [31:0] d);
        cyc(0, '0, 1, BASE, d);
    endtask
    task automatic rd_k(logic [31:0] off, logic [31:0] k, string nm);
        cyc(1, BASE + off, 0, '0, '0, 0, nm, 1, k);
    endtask
    task automatic wr_ctrl(logic [31:0] d);
        cyc(0, '0, 1, BASE + 32'h8, d);
    endtask

    function automatic logic [31:0] rand_addr();
        int sel;
        sel = $urandom_range(0, 11);
        if (sel == 0) return BASE + 32'h10 + 32'($urandom_range(0, 15));
        if (sel == 1) return BASE - 32'd4;
        if (sel < 7)  return BASE + 32'($urandom_range(0, 3));
        return BASE + 32'($urandom_range(0, 15));
    endfunction

    initial begin
        cyc(0, '0, 0, '0, '0, 1);
        started = 1;
        cyc(0, '0, 0, '0, '0, 1);

        push(32'h11); push(32'h22); push(32'h33);
        rd_k(0, 32'h11, "pop1"); rd_k(0, 32'h22, "pop2"); rd_k(0, 32'h33, "pop3");
        rd_k(4, 32'h0000_0001, "status_empty");

        for (int i = 0; i < 9; i++) push(32'hA0 + 32'(i));
        rd_k(4, 32'h0000_0806, "status_full_ovf");
        for (int i = 0; i < 8; i++) rd_k(0, 32'hA0 + 32'(i), "pop_a");
        wr_ctrl(32'h0002_0000);
        rd_k(4, 32'h0000_0001, "status_cleared");

        rd_k(0, 32'h0, "pop_empty");
        rd_k(4, 32'h0000_0009, "status_udf");
        cyc(1, BASE, 1, BASE, 32'h55, 0, "pop_push_empty", 1, 32'h0);
        rd_k(4, 32'h0000_0108, "status_cnt1");
        rd_k(0, 32'h55, "pop_55");

        wr_ctrl(32'h0002_0000);
        for (int i = 0; i < 8; i++) push(32'hC0 + 32'(i));
        cyc(1, BASE, 1, BASE, 32'hBB, 0, "pop_push_full", 1, 32'hC0);
        rd_k(4, 32'h0000_0802, "status_full_noovf");
        for (int i = 1; i < 8; i++) rd_k(0, 32'hC0 + 32'(i), "pop_c");
        rd_k(0, 32'hBB, "pop_bb");

        wr_ctrl(32'h0000_0301);
        push(32'h1); push(32'h2); push(32'h3);
        cyc(0, '0, 0, '0, '0);
        rd_k(0, 32'h1, "pop_irq");
        push(32'h4);
        wr_ctrl(32'h0001_0301);
        rd_k(8, 32'h0000_0301, "ctrl_rd");
        rd_k(4, 32'h0000_0001, "status_flushed");

        for (int i = 0; i < 5; i++) push(32'hD0 + 32'(i));
        cyc(1, BASE, 1, BASE, 32'hEE, 1);
        rd_k(4, 32'h0000_0001, "status_after_rst");
        rd_k(8, 32'h0, "ctrl_after_rst");
        rd_k(0, 32'h0, "pop_after_rst");
        rd_k(4, 32'h0000_0009, "status_udf_rst");

        for (int n = 0; n < 3000; n++) begin
            logic [31:0] wa, wd;
            wa = rand_addr();
            wd = $urandom;
            if (wa[3:2] == 2'd2 && wa - BASE < 32'd16) begin
                wd[16] = ($urandom_range(0, 7) == 0);
                wd[17] = ($urandom_range(0, 5) == 0);
                wd[12:8] = 5'($urandom_range(0, 10));
            end
            cyc($urandom_range(0, 2) != 0, rand_addr(), $urandom_range(0, 2) != 0, wa, wd,
                $urandom_range(0, 299) == 0, "rand");
        end
        cyc(0, '0, 0, '0, '0);
        cyc(0, '0, 0, '0, '0);
        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: got %0d leftover entries expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mbox.md
# mbox

Memory-mapped mailbox FIFO that responds to the core's data bus, alongside the timer and UART peripherals. The core pushes 32-bit words with bus writes and pops them with bus reads. Pop data returns one cycle later, matching the SoC's registered read-data mux. An optional level interrupt signals when the FIFO fill level reaches a programmed threshold.

## Interface

- `BASE_ADDR`, default 32'h0000_1000: byte address of register 0; the block decodes `BASE_ADDR`..`BASE_ADDR+0xF`.
- `DEPTH`, default 8: FIFO entries; must be a power of two, from 2 to 16.
- `clk` input, 1 bit: the single clock; all logic is on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `mbox_r_addr_i` input, 32 bits: bus read byte address.
- `mbox_w_addr_i` input, 32 bits: bus write byte address.
- `mbox_data_i` input, 32 bits: bus write data.
- `mbox_r_enable_i` input, 1 bit: read strobe, one cycle per access.
- `mbox_w_enable_i` input, 1 bit: write strobe, one cycle per access.
- `mbox_data_o` output, 32 bits: registered read data.
- `mbox_irq_o` output, 1 bit: level interrupt, registered.

## Operation

- Address decode:
  - Bits [1:0] are ignored; the word offset is `addr - BASE_ADDR`, bits [3:2].
  - Addresses outside the window are ignored entirely.
- Register map:
  - 0x0 DATA. Write pushes `mbox_data_i`; read pops the head entry.
  - 0x4 STATUS, read-only:
    - bit0 empty, bit1 full, bit2 overflow (sticky), bit3 underflow (sticky);
    - bits[12:8] count, zero-extended; all other bits 0.
  - 0x8 CTRL, read/write:
    - bit0 irq_en;
    - bits[12:8] threshold;
    - bit16 flush, write-1 pulse, reads 0;
    - bit17 clear-sticky, write-1 pulse, reads 0.
  - 0xC: reads 0; writes are ignored.
- Storage:
  - Circular buffer with write pointer, read pointer and count.
  - Count width is log2(DEPTH)+1; pointers wrap modulo DEPTH.
- Push, on a DATA write:
  - Not full, or a pop in the same cycle: store the word and advance the write pointer.
  - Full with no same-cycle pop: drop the word, leave the pointers unchanged, set overflow.
- Pop, on a DATA read:
  - Not empty: capture the head word into `mbox_data_o` and advance the read pointer.
  - Empty: load 0, leave the pointers unchanged, set underflow.
  - No bypass: a push and pop in the same cycle on an empty FIFO gives the push stored, pop returns 0, underflow set, count = 1.
- Simultaneous push and pop, neither condition empty: both succeed and count is unchanged. This includes the full case.
- Flush:
  - Pointers and count go to 0 and stored data is discarded.
  - Flush beats a same-cycle DATA write; the write is dropped without setting overflow.
  - A same-cycle DATA read returns the pre-flush head.
- Clear-sticky clears overflow and underflow. A same-cycle event that sets a flag wins over the clear.
- STATUS and CTRL reads return the state before the current cycle's updates.
- Read data:
  - `mbox_data_o` loads only in a cycle with `mbox_r_enable_i` and a decoded address.
  - Otherwise it holds its value.
  - It is not cleared between accesses.
- Interrupt: `mbox_irq_o` is registered as irq_en AND (threshold != 0) AND (count >= threshold), using post-update count. Threshold values above DEPTH never fire.

## Timing

- Reset values:
  - `mbox_data_o` = 0, `mbox_irq_o` = 0;
  - pointers and count = 0; overflow = underflow = 0; irq_en = 0; threshold = 0.
- Reset applies at the clock edge where `rst` is sampled high. Mid-operation it empties the FIFO and clears all state; a push or pop in that cycle is discarded.
- Read latency is one cycle: an access with the strobe in cycle N presents data on `mbox_data_o` in cycle N+1.
- Writes take effect at the edge that ends the strobe cycle; STATUS read in N+1 reflects them.
- Interrupt latency:
  - `mbox_irq_o` rises the cycle after the push that makes count reach threshold.
  - It falls the cycle after the pop, flush or CTRL write that breaks the condition.
- Back-to-back strobes on consecutive cycles are fully supported; there are no wait states.

## Test plan

- Reset, then push 0x11, 0x22, 0x33 and read DATA three times -> `mbox_data_o` is 0x11, 0x22, 0x33 on the cycle after each read; STATUS then reads 0x0000_0001.
- Push 9 words 0xA0..0xA8 with DEPTH=8 -> STATUS = 0x0000_0806 (count 8, full, overflow); the 8 pops return 0xA0..0xA7; clear-sticky makes bit2 read 0.
- Read DATA when empty -> `mbox_data_o` = 0 and STATUS bit3 = 1. Then, while empty, push 0x55 and pop in the same cycle -> data 0, count 1, and the next pop returns 0x55.
- Fill to full and issue a push of 0xBB together with a pop -> the pop returns the oldest word, count stays 8, overflow stays 0, and 0xBB is the last word popped.
- Write CTRL = 0x0000_0301 (irq_en, threshold 3) and push 3 words -> `mbox_irq_o` rises the cycle after the third push; one pop drops it the next cycle; CTRL flush empties the FIFO and reads 0 in bit16.
- Assert `rst` for one cycle after 5 pushes -> STATUS = 0x0000_0001, CTRL = 0, `mbox_irq_o` = 0, and a following pop returns 0 with underflow set.
